mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises instruction fetches and load/stores onto a
// byte-wide RAM, with rollback of speculative reads and UART back-pressure on stores.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_fetch_req,
    input  logic [31:0] in_fetch_addr,
    output logic        out_fetch_ok,
    output logic [31:0] out_fetch_data,
    input  logic        in_ls_req,
    input  logic        in_ls_iswrite,
    input  logic [31:0] in_ls_addr,
    input  logic [2:0]  in_ls_size,
    input  logic [31:0] in_ls_data,
    output logic        out_ls_ok,
    output logic [31:0] out_ls_data,
    input  logic        in_rollback,
    input  logic        in_io_full,
    output logic [31:0] out_ram_addr,
    output logic [7:0]  out_ram_data,
    output logic        out_ram_wr,
    input  logic [7:0]  in_ram_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LS_READ  = 3'd2,
        LS_WRITE = 3'd3,
        IO_WAIT  = 3'd4
    } state_t;

    state_t      state_r, state_nx;
    logic [2:0]  cnt_r, nbytes_r;
    logic [31:0] addr_r, wdata_r, rdbuf_r, fetch_data_r, ls_data_r;
    logic        last_ls_r, stalled_r, fetch_ok_r, ls_ok_r;

    logic        grant_ls_s, grant_fetch_s, is_read_s, is_write_s, io_addr_s;
    logic        write_go_s, last_byte_s, read_step_s, read_done_s;
    logic [31:0] capture_word_s, ram_addr_s;
    logic [7:0]  ram_data_s;
    logic        ram_wr_s;

    function automatic logic [2:0] size_decode(input logic [2:0] size);
        case (size)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] insert_byte(input logic [31:0] word, input logic [1:0] idx,
                                                input logic [7:0] value);
        logic [31:0] w;
        w = word;
        w[{idx, 3'b000} +: 8] = value;
        return w;
    endfunction

    // LS wins a tie unless it was the last one served
    assign grant_ls_s    = in_ls_req && (!in_fetch_req || !last_ls_r);
    assign grant_fetch_s = in_fetch_req && !grant_ls_s;
    assign is_read_s     = (state_r == FETCH) || (state_r == LS_READ);
    assign is_write_s    = (state_r == LS_WRITE) || (state_r == IO_WAIT);
    assign io_addr_s     = (addr_r[17:16] == 2'b11);
    assign write_go_s    = ena && is_write_s && !(io_addr_s && in_io_full);
    assign last_byte_s   = (cnt_r == (nbytes_r - 3'd1));
    // A replay cycle after a stall re-issues the in-flight address and captures nothing
    assign read_step_s   = ena && is_read_s && !in_rollback && !stalled_r;
    assign read_done_s   = read_step_s && (cnt_r == nbytes_r);
    assign capture_word_s = insert_byte(rdbuf_r, cnt_r[1:0] - 2'd1, in_ram_data);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_r;
        if (!ena) begin
            state_nx = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_rollback) begin
                        state_nx = IDLE;
                    end else if (grant_ls_s) begin
                        state_nx = in_ls_iswrite ? LS_WRITE : LS_READ;
                    end else if (grant_fetch_s) begin
                        state_nx = FETCH;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                FETCH, LS_READ: begin
                    if (in_rollback || read_done_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = state_r;
                    end
                end
                LS_WRITE, IO_WAIT: begin
                    if (!write_go_s) begin
                        state_nx = IO_WAIT;
                    end else if (last_byte_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = LS_WRITE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // RAM-side outputs decoded from state
    always_comb begin
        ram_addr_s = 32'd0;
        ram_data_s = 8'd0;
        ram_wr_s   = 1'b0;
        case (state_r)
            FETCH, LS_READ: begin
                if (stalled_r) begin
                    ram_addr_s = addr_r + {29'd0, cnt_r - 3'd1};
                end else if (cnt_r != nbytes_r) begin
                    ram_addr_s = addr_r + {29'd0, cnt_r};
                end else begin
                    ram_addr_s = 32'd0;
                end
            end
            LS_WRITE, IO_WAIT: begin
                ram_addr_s = addr_r + {29'd0, cnt_r};
                ram_data_s = wdata_r[{cnt_r[1:0], 3'b000} +: 8];
                ram_wr_s   = write_go_s;
            end
            default: begin
                ram_addr_s = 32'd0;
                ram_data_s = 8'd0;
                ram_wr_s   = 1'b0;
            end
        endcase
    end

    assign out_ram_addr   = ram_addr_s;
    assign out_ram_data   = ram_data_s;
    assign out_ram_wr     = ram_wr_s;
    assign out_fetch_ok   = fetch_ok_r && ena;
    assign out_ls_ok      = ls_ok_r && ena;
    assign out_fetch_data = fetch_data_r;
    assign out_ls_data    = ls_data_r;

    // Operand capture, byte counting, read assembly and done pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r        <= 3'd0;
            nbytes_r     <= 3'd0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            rdbuf_r      <= 32'd0;
            fetch_data_r <= 32'd0;
            ls_data_r    <= 32'd0;
            last_ls_r    <= 1'b0;
            stalled_r    <= 1'b0;
            fetch_ok_r   <= 1'b0;
            ls_ok_r      <= 1'b0;
        end else if (!ena) begin
            // ok pulses and data hold so the pulse lands on the next enabled cycle
            if (is_read_s && (cnt_r != 3'd0)) begin
                stalled_r <= 1'b1;
            end
        end else begin
            stalled_r  <= 1'b0;
            fetch_ok_r <= 1'b0;
            ls_ok_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!in_rollback && (grant_ls_s || grant_fetch_s)) begin
                        cnt_r   <= 3'd0;
                        rdbuf_r <= 32'd0;
                        if (grant_ls_s) begin
                            addr_r    <= in_ls_addr;
                            nbytes_r  <= size_decode(in_ls_size);
                            wdata_r   <= in_ls_data;
                            last_ls_r <= 1'b1;
                        end else begin
                            addr_r    <= in_fetch_addr;
                            nbytes_r  <= 3'd4;
                            last_ls_r <= 1'b0;
                        end
                    end
                end
                FETCH, LS_READ: begin
                    if (read_step_s) begin
                        if (cnt_r != 3'd0) begin
                            rdbuf_r <= capture_word_s;
                        end
                        if (read_done_s) begin
                            if (state_r == FETCH) begin
                                fetch_ok_r   <= 1'b1;
                                fetch_data_r <= capture_word_s;
                            end else begin
                                ls_ok_r   <= 1'b1;
                                ls_data_r <= capture_word_s;
                            end
                        end else begin
                            cnt_r <= cnt_r + 3'd1;
                        end
                    end
                end
                LS_WRITE, IO_WAIT: begin
                    if (write_go_s) begin
                        if (last_byte_s) begin
                            ls_ok_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 3'd1;
                        end
                    end
                end
                default: begin
                    cnt_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, a negedge
// monitor pops and compares on every ok pulse and every RAM write.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, ena;
    logic        in_fetch_req, in_ls_req, in_ls_iswrite, in_rollback, in_io_full;
    logic [31:0] in_fetch_addr, in_ls_addr, in_ls_data;
    logic [2:0]  in_ls_size;
    logic [7:0]  in_ram_data = 8'd0;
    logic        out_fetch_ok, out_ls_ok, out_ram_wr;
    logic [31:0] out_fetch_data, out_ls_data, out_ram_addr;
    logic [7:0]  out_ram_data;

    typedef struct { logic [31:0] data; int cyc; bit chk_data; } rsp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
    rsp_t fetch_q[$];
    rsp_t ls_q[$];
    wr_t  wr_q[$];
    bit   order_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr),
        .out_fetch_ok(out_fetch_ok), .out_fetch_data(out_fetch_data),
        .in_ls_req(in_ls_req), .in_ls_iswrite(in_ls_iswrite), .in_ls_addr(in_ls_addr),
        .in_ls_size(in_ls_size), .in_ls_data(in_ls_data),
        .out_ls_ok(out_ls_ok), .out_ls_data(out_ls_data),
        .in_rollback(in_rollback), .in_io_full(in_io_full),
        .out_ram_addr(out_ram_addr), .out_ram_data(out_ram_data), .out_ram_wr(out_ram_wr),
        .in_ram_data(in_ram_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (a == 32'h0000_1000) return 8'h13;
        else if (a >= 32'h0000_1001 && a <= 32'h0000_1003) return 8'h00;
        else return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ram_byte(a + 32'(k));
        return w;
    endfunction

    function automatic int dec_size(input logic [2:0] sz);
        return (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
    endfunction

    // RAM model: byte for the address seen at an edge is presented the following cycle
    always @(posedge clk) in_ram_data <= ram_byte(out_ram_addr);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        if (rst) begin
            if (out_fetch_ok) begin
                chk("fetch_ok_expected", 64'(fetch_q.size() != 0), 64'd1);
                chk("order_expected", 64'(order_q.size() != 0), 64'd1);
                if (order_q.size() != 0) chk("grant_order", 64'(1'b0), 64'(order_q.pop_front()));
                if (fetch_q.size() != 0) begin
                    r = fetch_q.pop_front();
                    chk("fetch_data", 64'(out_fetch_data), 64'(r.data));
                    if (r.cyc >= 0) chk("fetch_ok_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            if (out_ls_ok) begin
                chk("ls_ok_expected", 64'(ls_q.size() != 0), 64'd1);
                chk("order_expected", 64'(order_q.size() != 0), 64'd1);
                if (order_q.size() != 0) chk("grant_order", 64'(1'b1), 64'(order_q.pop_front()));
                if (ls_q.size() != 0) begin
                    r = ls_q.pop_front();
                    if (r.chk_data) chk("ls_data", 64'(out_ls_data), 64'(r.data));
                    if (r.cyc >= 0) chk("ls_ok_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            if (out_ram_wr) begin
                chk("ram_wr_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    chk("ram_wr_addr", 64'(out_ram_addr), 64'(w.addr));
                    chk("ram_wr_data", 64'(out_ram_data), 64'(w.data));
                    if (w.cyc >= 0) chk("ram_wr_cycle", 64'(cyc), 64'(w.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ok(input bit is_ls);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = is_ls ? out_ls_ok : out_fetch_ok;
        end
        chk(is_ls ? "ls_ok_timeout" : "fetch_ok_timeout", 64'(seen), 64'd1);
    endtask

    task automatic issue_fetch(input logic [31:0] a, input bit timed, input bit ord);
        fetch_q.push_back('{data: exp_word(a, 4), cyc: timed ? cyc + 6 : -1, chk_data: 1'b1});
        if (ord) order_q.push_back(1'b0);
        in_fetch_addr = a;
        in_fetch_req  = 1'b1;
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [2:0] sz, input bit timed,
                              input int extra, input bit ord);
        int n;
        n = dec_size(sz);
        ls_q.push_back('{data: exp_word(a, n), cyc: timed ? cyc + n + 2 + extra : -1, chk_data: 1'b1});
        if (ord) order_q.push_back(1'b1);
        in_ls_addr = a; in_ls_size = sz; in_ls_iswrite = 1'b0; in_ls_req = 1'b1;
    endtask

    task automatic issue_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                               input int io_hold, input bit timed);
        int n, g;
        n = dec_size(sz);
        g = cyc + 1;
        for (int k = 0; k < n; k++)
            wr_q.push_back('{addr: a + 32'(k), data: d[8*k +: 8], cyc: timed ? g + io_hold + k : -1});
        ls_q.push_back('{data: 32'd0, cyc: timed ? g + io_hold + n : -1, chk_data: 1'b0});
        order_q.push_back(1'b1);
        in_ls_addr = a; in_ls_size = sz; in_ls_data = d; in_ls_iswrite = 1'b1; in_ls_req = 1'b1;
        in_io_full = (io_hold > 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {out_ram_addr, out_ram_data, out_ram_wr, out_fetch_ok, out_ls_ok}, 64'd0);
        chk({name, "_data"}, {out_fetch_data, out_ls_data}, 64'd0);
    endtask

    initial begin
        rst = 1'b0; ena = 1'b1;
        in_fetch_req = 1'b0; in_ls_req = 1'b0; in_ls_iswrite = 1'b0; in_rollback = 1'b0;
        in_io_full = 1'b0; in_fetch_addr = 32'd0; in_ls_addr = 32'd0; in_ls_data = 32'd0;
        in_ls_size = 3'd0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");

        // Fetch 0x1000 granted on the first edge after reset release
        rst = 1'b1;
        issue_fetch(32'h0000_1000, 1'b1, 1'b1);
        wait_ok(1'b0); in_fetch_req = 1'b0;
        tick();

        // Store size 2 then loads of every size encoding
        issue_store(32'h0000_0200, 3'd2, 32'hAABB_CCDD, 0, 1'b1);
        wait_ok(1'b1); in_ls_req = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) begin
            logic [2:0] sizes [5] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0};
            issue_load(32'h0000_0120 + 32'(s * 8), sizes[s], 1'b1, 0, 1'b1);
            wait_ok(1'b1); in_ls_req = 1'b0;
            tick();
        end

        // After reset LS wins the tie, then held requests alternate
        rst = 1'b0; tick(); rst = 1'b1;
        order_q.push_back(1'b1); order_q.push_back(1'b0);
        order_q.push_back(1'b1); order_q.push_back(1'b0);
        fork
            begin
                issue_load(32'h0000_0080, 3'd4, 1'b1, 0, 1'b0); wait_ok(1'b1);
                issue_load(32'h0000_0090, 3'd2, 1'b0, 0, 1'b0); wait_ok(1'b1);
                in_ls_req = 1'b0;
            end
            begin
                issue_fetch(32'h0000_1040, 1'b0, 1'b0); wait_ok(1'b0);
                issue_fetch(32'h0000_1050, 1'b0, 1'b0); wait_ok(1'b0);
                in_fetch_req = 1'b0;
            end
        join
        tick();

        // Rollback on the second fetch cycle
        in_fetch_addr = 32'h0000_1000; in_fetch_req = 1'b1;
        tick(); chk("fetch_addr0", 64'(out_ram_addr), 64'h1000);
        tick(); chk("fetch_addr1", 64'(out_ram_addr), 64'h1001);
        in_rollback = 1'b1; in_fetch_req = 1'b0;
        #1 chk("rollback_wr", 64'(out_ram_wr), 64'd0);
        tick(); in_rollback = 1'b0;
        chk("rollback_idle_addr", 64'(out_ram_addr), 64'd0);
        repeat (8) tick();

        // Request coincident with rollback is not granted
        in_fetch_addr = 32'h0000_1000; in_fetch_req = 1'b1; in_rollback = 1'b1;
        tick(); in_fetch_req = 1'b0; in_rollback = 1'b0;
        #1 chk("rollback_no_grant", 64'(out_ram_addr), 64'd0);
        tick();

        // Rollback during a store does not abort it
        issue_store(32'h0000_0300, 3'd4, 32'h1122_3344, 0, 1'b1);
        tick(); tick(); in_rollback = 1'b1;
        tick(); in_rollback = 1'b0;
        wait_ok(1'b1); in_ls_req = 1'b0;
        tick();

        // UART store held off for three cycles
        issue_store(32'h0003_0000, 3'd1, 32'h0000_0041, 3, 1'b1);
        repeat (4) tick();
        in_io_full = 1'b0;
        wait_ok(1'b1); in_ls_req = 1'b0;
        tick();

        // ena low two cycles mid-load, then mid-store
        issue_load(32'h0000_1044, 3'd4, 1'b0, 0, 1'b1);
        tick(); tick(); ena = 1'b0;
        tick(); tick(); ena = 1'b1;
        wait_ok(1'b1); in_ls_req = 1'b0;
        tick();
        issue_store(32'h0000_0400, 3'd4, 32'hCAFE_F00D, 0, 1'b0);
        tick(); tick(); ena = 1'b0;
        #1 chk("ena_low_wr", 64'(out_ram_wr), 64'd0);
        tick(); chk("ena_low_wr2", 64'(out_ram_wr), 64'd0);
        tick(); ena = 1'b1;
        wait_ok(1'b1); in_ls_req = 1'b0;
        tick();

        // ena low in the ok cycle defers the pulse by one cycle
        issue_load(32'h0000_0055, 3'd1, 1'b1, 1, 1'b1);
        repeat (3) tick(); ena = 1'b0;
        #1 chk("ok_masked", 64'(out_ls_ok), 64'd0);
        tick(); ena = 1'b1; in_ls_req = 1'b0;
        repeat (3) tick();

        // Reset mid-load discards the transfer
        in_ls_addr = 32'h0000_1000; in_ls_size = 3'd4; in_ls_iswrite = 1'b0; in_ls_req = 1'b1;
        tick(); tick(); rst = 1'b0; in_ls_req = 1'b0;
        #1 chk_all_zero("midload_reset");
        tick(); rst = 1'b1;
        repeat (8) tick();

        chk("fetch_q_drained", 64'(fetch_q.size()), 64'd0);
        chk("ls_q_drained", 64'(ls_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("order_q_drained", 64'(order_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
